apb_slave_regbank: RTL and testbench

//  APB completer (slave): a register bank answering the APB requester side of the AHB-to-APB bridge.

---
 rtl/apb_slave_regbank_pkg.sv | 18 +
 rtl/apb_slave_regbank_regfile.sv | 43 ++++
 rtl/apb_slave_regbank.sv | 148 ++++++++++++++
 tb/tb_apb_slave_regbank.sv | 341 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/apb_slave_regbank_pkg.sv
// Shared types and constants for the APB register-bank completer.
package apb_slave_regbank_pkg;

  localparam int APB_DATA_W = 32;
  localparam int APB_SEL_W  = 3;
  localparam int APB_WAIT_W = 4;

  typedef enum logic {
    APB_IDLE   = 1'b0,
    APB_ACCESS = 1'b1
  } apb_state_e;

  // Error counter step that sticks at all-ones instead of wrapping.
  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/apb_slave_regbank_regfile.sv
// DEPTH x 32 register storage: async clear to RESET_VAL, one sync write port,
// one combinational read port.
module apb_slave_regbank_regfile
  import apb_slave_regbank_pkg::*;
#(
  parameter int                    DEPTH     = 16,
  parameter logic [APB_DATA_W-1:0] RESET_VAL = '0,
  localparam int                   AW        = $clog2(DEPTH)
) (
  input  logic                  Hclk,
  input  logic                  Hreset,
  input  logic                  wr_en,
  input  logic [AW-1:0]         wr_idx,
  input  logic [APB_DATA_W-1:0] wr_data,
  input  logic [AW-1:0]         rd_idx,
  output logic [APB_DATA_W-1:0] rd_data
);

  logic [APB_DATA_W-1:0] mem_q [DEPTH];
  logic [APB_DATA_W-1:0] mem_d [DEPTH];

  // Next storage contents: only the addressed word changes on a write.
  always_comb begin
    mem_d = mem_q;
    if (wr_en) begin
      mem_d[wr_idx] = wr_data;
    end
  end

  // Storage flops, cleared to the reset pattern asynchronously.
  always_ff @(posedge Hclk or negedge Hreset) begin
    if (!Hreset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= RESET_VAL;
      end
    end else begin
      mem_q <= mem_d;
    end
  end

  assign rd_data = mem_q[rd_idx];

endmodule

// File: rtl/apb_slave_regbank.sv
// APB completer register bank: address decode, transfer FSM, wait-state
// counter and saturating protocol-violation counter around a register file.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// APB_IDLE   | no transfer in flight; waiting for a setup phase
// APB_ACCESS | setup latched; counting wait states until completion
module apb_slave_regbank
  import apb_slave_regbank_pkg::*;
#(
  parameter int                    SLAVE_IDX   = 0,
  parameter logic [APB_DATA_W-1:0] BASE_ADDR   = 32'h8000_0000,
  parameter int                    DEPTH       = 16,
  parameter int                    WAIT_STATES = 0,
  parameter logic [APB_DATA_W-1:0] RESET_VAL   = 32'h0
) (
  input  logic                  Hclk,
  input  logic                  Hreset,
  input  logic [APB_SEL_W-1:0]  Pselx,
  input  logic                  Penable,
  input  logic                  Pwrite,
  input  logic [31:0]           Paddr,
  input  logic [APB_DATA_W-1:0] Pwdata,
  output logic [APB_DATA_W-1:0] Prdata,
  output logic                  Pready,
  output logic                  Pslverr,
  output logic [7:0]            prot_err_cnt
);

  localparam int                    AW        = $clog2(DEPTH);
  localparam logic [29:0]           DEPTH_W   = 30'(DEPTH);
  localparam logic [APB_WAIT_W-1:0] WAIT_LOAD = APB_WAIT_W'(WAIT_STATES);

  apb_state_e            state_q, state_d;
  logic [AW-1:0]         idx_q, idx_d;
  logic                  bad_q, bad_d;
  logic                  write_q, write_d;
  logic [APB_DATA_W-1:0] wdata_q, wdata_d;
  logic [APB_WAIT_W-1:0] wait_q, wait_d;
  logic [7:0]            cnt_q, cnt_d;

  logic                  sel;
  logic [31:0]           off;
  logic                  bad;
  logic [AW-1:0]         idx;
  logic                  complete;
  logic                  wr_en;
  logic [APB_DATA_W-1:0] rd_data;
  logic                  sel_unused;

  assign sel        = Pselx[SLAVE_IDX];
  assign sel_unused = ^Pselx;

  // Address decode relative to the bank base; anything outside the bank or
  // not word aligned is flagged so it answers with an error.
  always_comb begin
    off = Paddr - BASE_ADDR;
    bad = (Paddr < BASE_ADDR) | (off[1:0] != 2'b00) | (off[31:2] >= DEPTH_W);
    idx = off[AW+1:2];
  end

  assign complete = (state_q == APB_ACCESS) && sel && Penable && (wait_q == '0);

  // Transfer sequencing; a repeated setup or lost select counts as a violation.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    bad_d   = bad_q;
    write_d = write_q;
    wdata_d = wdata_q;
    wait_d  = wait_q;
    cnt_d   = cnt_q;
    wr_en   = 1'b0;
    case (state_q)
      APB_IDLE: begin
        if (sel && !Penable) begin
          idx_d   = idx;
          bad_d   = bad;
          write_d = Pwrite;
          wdata_d = Pwdata;
          wait_d  = WAIT_LOAD;
          state_d = APB_ACCESS;
        end else if (sel && Penable) begin
          cnt_d = sat_inc8(cnt_q);
        end
      end
      APB_ACCESS: begin
        if (!sel) begin
          cnt_d   = sat_inc8(cnt_q);
          state_d = APB_IDLE;
        end else if (!Penable) begin
          cnt_d   = sat_inc8(cnt_q);
          idx_d   = idx;
          bad_d   = bad;
          write_d = Pwrite;
          wdata_d = Pwdata;
          wait_d  = WAIT_LOAD;
        end else if (wait_q != '0) begin
          wait_d = wait_q - 1'b1;
        end else begin
          wr_en   = write_q && !bad_q;
          state_d = APB_IDLE;
        end
      end
      default: state_d = APB_IDLE;
    endcase
  end

  // Control and counter flops.
  always_ff @(posedge Hclk or negedge Hreset) begin
    if (!Hreset) begin
      state_q <= APB_IDLE;
      idx_q   <= '0;
      bad_q   <= 1'b0;
      write_q <= 1'b0;
      wdata_q <= '0;
      wait_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      bad_q   <= bad_d;
      write_q <= write_d;
      wdata_q <= wdata_d;
      wait_q  <= wait_d;
      cnt_q   <= cnt_d;
    end
  end

  apb_slave_regbank_regfile #(
    .DEPTH     (DEPTH),
    .RESET_VAL (RESET_VAL)
  ) u_regfile (
    .Hclk    (Hclk),
    .Hreset  (Hreset),
    .wr_en   (wr_en),
    .wr_idx  (idx_q),
    .wr_data (wdata_q),
    .rd_idx  (idx_q),
    .rd_data (rd_data)
  );

  assign Pready       = complete;
  assign Pslverr      = complete && bad_q;
  assign Prdata       = (complete && !write_q && !bad_q) ? rd_data : '0;
  assign prot_err_cnt = cnt_q;

endmodule

// File: tb/tb_apb_slave_regbank.sv
// Bench for apb_slave_regbank: three completers on one shared APB bus with
// different select bits, wait states and reset patterns.
module tb_apb_slave_regbank;

  localparam logic [31:0] BASE = 32'h8000_0000;

  logic        Hclk = 1'b0;
  logic        Hreset;
  logic [2:0]  Pselx;
  logic        Penable;
  logic        Pwrite;
  logic [31:0] Paddr;
  logic [31:0] Pwdata;

  logic [31:0] prdata0, prdata1, prdata2;
  logic        pready0, pready1, pready2;
  logic        pslverr0, pslverr1, pslverr2;
  logic [7:0]  cnt0, cnt1, cnt2;

  logic [31:0] prdata  [3];
  logic        pready  [3];
  logic        pslverr [3];
  logic [7:0]  cnt     [3];

  assign prdata[0] = prdata0;   assign prdata[1] = prdata1;   assign prdata[2] = prdata2;
  assign pready[0] = pready0;   assign pready[1] = pready1;   assign pready[2] = pready2;
  assign pslverr[0] = pslverr0; assign pslverr[1] = pslverr1; assign pslverr[2] = pslverr2;
  assign cnt[0] = cnt0;         assign cnt[1] = cnt1;         assign cnt[2] = cnt2;

  always #5 Hclk = ~Hclk;

  apb_slave_regbank #(.SLAVE_IDX(0), .BASE_ADDR(BASE), .DEPTH(16), .WAIT_STATES(0),
                      .RESET_VAL(32'h0)) dut0 (
    .Hclk(Hclk), .Hreset(Hreset), .Pselx(Pselx), .Penable(Penable), .Pwrite(Pwrite),
    .Paddr(Paddr), .Pwdata(Pwdata), .Prdata(prdata0), .Pready(pready0),
    .Pslverr(pslverr0), .prot_err_cnt(cnt0));

  apb_slave_regbank #(.SLAVE_IDX(1), .BASE_ADDR(BASE), .DEPTH(16), .WAIT_STATES(3),
                      .RESET_VAL(32'hA5A5_0001)) dut1 (
    .Hclk(Hclk), .Hreset(Hreset), .Pselx(Pselx), .Penable(Penable), .Pwrite(Pwrite),
    .Paddr(Paddr), .Pwdata(Pwdata), .Prdata(prdata1), .Pready(pready1),
    .Pslverr(pslverr1), .prot_err_cnt(cnt1));

  apb_slave_regbank #(.SLAVE_IDX(2), .BASE_ADDR(BASE), .DEPTH(16), .WAIT_STATES(2),
                      .RESET_VAL(32'h0000_00C3)) dut2 (
    .Hclk(Hclk), .Hreset(Hreset), .Pselx(Pselx), .Penable(Penable), .Pwrite(Pwrite),
    .Paddr(Paddr), .Pwdata(Pwdata), .Prdata(prdata2), .Pready(pready2),
    .Pslverr(pslverr2), .prot_err_cnt(cnt2));

  int n_checks = 0;
  int n_errors = 0;

  // Transaction-level model of the three banks.
  logic [31:0] m_mem [3][16];
  logic [7:0]  m_cnt [3];

  function automatic int ws_of(input int s);
    return (s == 0) ? 0 : (s == 1) ? 3 : 2;
  endfunction

  function automatic logic [31:0] rv_of(input int s);
    return (s == 0) ? 32'h0 : (s == 1) ? 32'hA5A5_0001 : 32'h0000_00C3;
  endfunction

  function automatic bit m_bad(input logic [31:0] a);
    logic [31:0] off;
    off = a - BASE;
    if (a < BASE) return 1'b1;
    if (off[1:0] != 2'b00) return 1'b1;
    return (off >> 2) >= 32'd16;
  endfunction

  function automatic int m_idx(input logic [31:0] a);
    return int'((a - BASE) >> 2);
  endfunction

  task automatic model_reset();
    for (int s = 0; s < 3; s++) begin
      m_cnt[s] = 8'h0;
      for (int r = 0; r < 16; r++) m_mem[s][r] = rv_of(s);
    end
  endtask

  task automatic bump(input int s);
    if (m_cnt[s] != 8'hFF) m_cnt[s] = m_cnt[s] + 8'd1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic idle(input int n);
    Pselx   = 3'b000;
    Penable = 1'b0;
    repeat (n) begin @(posedge Hclk); #1; end
  endtask

  task automatic drive_setup(input int s, input bit w, input logic [31:0] a, input logic [31:0] d);
    Pselx   = 3'b001 << s;
    Penable = 1'b0;
    Pwrite  = w;
    Paddr   = a;
    Pwdata  = d;
  endtask

  // Runs the access phase after a setup has been driven; returns at the
  // completion edge + 1 with the bus still asserted.
  task automatic access_phase(input int s, input logic [31:0] d,
                              output logic [31:0] rd, output logic err, output int waits);
    bit done;
    done  = 1'b0;
    waits = 0;
    rd    = 32'h0;
    err   = 1'b0;
    @(posedge Hclk); #1;
    Penable = 1'b1;
    Pwdata  = ~d;
    for (int c = 0; c < 40 && !done; c++) begin
      @(negedge Hclk);
      for (int o = 0; o < 3; o++)
        if (o != s) chk($sformatf("unselected_pready%0d", o), 32'(pready[o]), 32'h0);
      if (pready[s]) begin
        rd   = prdata[s];
        err  = pslverr[s];
        done = 1'b1;
      end else begin
        chk("wait_prdata", prdata[s], 32'h0);
        chk("wait_pslverr", 32'(pslverr[s]), 32'h0);
        waits++;
      end
      @(posedge Hclk); #1;
    end
    if (!done) begin
      n_checks++;
      n_errors++;
      $display("FAIL timeout slave%0d: Pready got 0 for 40 cycles, required 1", s);
    end
  endtask

  task automatic xfer(input int s, input bit w, input logic [31:0] a, input logic [31:0] d,
                      output logic [31:0] rd, output logic err, output int waits);
    drive_setup(s, w, a, d);
    access_phase(s, d, rd, err, waits);
  endtask

  task automatic xfer_model(input int s, input bit w, input logic [31:0] a,
                            input logic [31:0] d, input string tag);
    logic [31:0] rd, exp_rd;
    logic        err, exp_err;
    int          waits;
    exp_err = m_bad(a);
    exp_rd  = (!w && !exp_err) ? m_mem[s][m_idx(a)] : 32'h0;
    xfer(s, w, a, d, rd, err, waits);
    chk({tag, "_pslverr"}, 32'(err), 32'(exp_err));
    chk({tag, "_prdata"}, rd, exp_rd);
    chk({tag, "_waits"}, 32'(waits), 32'(ws_of(s)));
    if (w && !exp_err) m_mem[s][m_idx(a)] = d;
  endtask

  typedef struct {
    int          s;
    bit          w;
    logic [31:0] a;
    logic [31:0] d;
    logic        err;
    logic [31:0] rd;
  } vec_t;

  vec_t tbl [12];

  initial begin
    logic [31:0] rd;
    logic        err;
    int          waits;

    tbl[0]  = '{0, 1'b1, 32'h8000_0008, 32'hDEAD_BEEF, 1'b0, 32'h0};
    tbl[1]  = '{0, 1'b0, 32'h8000_0008, 32'h0,         1'b0, 32'hDEAD_BEEF};
    tbl[2]  = '{1, 1'b0, 32'h8000_0000, 32'h0,         1'b0, 32'hA5A5_0001};
    tbl[3]  = '{0, 1'b1, 32'h8000_0040, 32'h1234_5678, 1'b1, 32'h0};
    tbl[4]  = '{0, 1'b0, 32'h8000_0002, 32'h0,         1'b1, 32'h0};
    tbl[5]  = '{0, 1'b0, 32'h8000_0000, 32'h0,         1'b0, 32'h0};
    tbl[6]  = '{0, 1'b1, 32'h8000_003C, 32'hCAFE_F00D, 1'b0, 32'h0};
    tbl[7]  = '{0, 1'b0, 32'h8000_003C, 32'h0,         1'b0, 32'hCAFE_F00D};
    tbl[8]  = '{0, 1'b0, 32'h7FFF_FFFC, 32'h0,         1'b1, 32'h0};
    tbl[9]  = '{2, 1'b0, 32'h8000_0008, 32'h0,         1'b0, 32'h0000_00C3};
    tbl[10] = '{1, 1'b1, 32'h8000_0010, 32'h0123_4567, 1'b0, 32'h0};
    tbl[11] = '{1, 1'b0, 32'h8000_0010, 32'h0,         1'b0, 32'h0123_4567};

    Hreset  = 1'b0;
    Pselx   = 3'b000;
    Penable = 1'b0;
    Pwrite  = 1'b0;
    Paddr   = 32'h0;
    Pwdata  = 32'h0;
    model_reset();
    repeat (2) @(posedge Hclk);
    #1 Hreset = 1'b1;

    // Reset state of every completer.
    @(negedge Hclk);
    for (int s = 0; s < 3; s++) begin
      chk($sformatf("reset_pready%0d", s), 32'(pready[s]), 32'h0);
      chk($sformatf("reset_pslverr%0d", s), 32'(pslverr[s]), 32'h0);
      chk($sformatf("reset_prdata%0d", s), prdata[s], 32'h0);
      chk($sformatf("reset_cnt%0d", s), 32'(cnt[s]), 32'h0);
    end

    // Reset asserted in the completing cycle of a write (2 wait states).
    drive_setup(2, 1'b1, 32'h8000_0004, 32'h1111_2222);
    @(posedge Hclk); #1;
    Penable = 1'b1;
    repeat (2) begin
      @(negedge Hclk);
      chk("rst_wait_pready", 32'(pready[2]), 32'h0);
      @(posedge Hclk); #1;
    end
    @(negedge Hclk);
    chk("rst_pre_pready", 32'(pready[2]), 32'h1);
    #1 Hreset = 1'b0;
    #1;
    chk("rst_pready", 32'(pready[2]), 32'h0);
    chk("rst_pslverr", 32'(pslverr[2]), 32'h0);
    chk("rst_prdata", prdata[2], 32'h0);
    Pselx   = 3'b000;
    Penable = 1'b0;
    @(posedge Hclk); @(posedge Hclk); #1;
    Hreset = 1'b1;
    model_reset();
    @(negedge Hclk);
    chk("rst_cnt", 32'(cnt[2]), 32'h0);
    xfer_model(2, 1'b0, 32'h8000_0004, 32'h0, "rst_readback");
    idle(1);

    // Directed vector table, applied back to back.
    for (int i = 0; i < 12; i++) begin
      xfer(tbl[i].s, tbl[i].w, tbl[i].a, tbl[i].d, rd, err, waits);
      chk($sformatf("tbl%0d_pslverr", i), 32'(err), 32'(tbl[i].err));
      chk($sformatf("tbl%0d_prdata", i), rd, tbl[i].rd);
      chk($sformatf("tbl%0d_waits", i), 32'(waits), 32'(ws_of(tbl[i].s)));
      if (tbl[i].w && !tbl[i].err) m_mem[tbl[i].s][m_idx(tbl[i].a)] = tbl[i].d;
    end
    idle(1);

    // Access phase without a setup.
    Pselx   = 3'b010;
    Penable = 1'b1;
    bump(1);
    @(posedge Hclk); #1;
    Pselx   = 3'b000;
    Penable = 1'b0;
    @(negedge Hclk);
    chk("viol_nosetup_cnt", 32'(cnt[1]), 32'h1);
    chk("viol_other_cnt", 32'(cnt[0]), 32'h0);

    // Select dropped after one wait cycle: aborted, nothing written.
    drive_setup(1, 1'b1, 32'h8000_0010, 32'h5555_5555);
    @(posedge Hclk); #1;
    Penable = 1'b1;
    @(posedge Hclk); #1;
    Pselx   = 3'b000;
    Penable = 1'b0;
    bump(1);
    @(posedge Hclk); #1;
    @(negedge Hclk);
    chk("viol_abort_cnt", 32'(cnt[1]), 32'h2);
    xfer_model(1, 1'b0, 32'h8000_0010, 32'h0, "abort_readback");
    idle(1);

    // Repeated setup mid-access: relatch the new transfer and reload waits.
    drive_setup(2, 1'b1, 32'h8000_000C, 32'hAAAA_AAAA);
    @(posedge Hclk); #1;
    Penable = 1'b1;
    @(posedge Hclk); #1;
    drive_setup(2, 1'b1, 32'h8000_0014, 32'hBBBB_BBBB);
    bump(2);
    access_phase(2, 32'hBBBB_BBBB, rd, err, waits);
    chk("resetup_pslverr", 32'(err), 32'h0);
    chk("resetup_waits", 32'(waits), 32'h2);
    m_mem[2][5] = 32'hBBBB_BBBB;
    idle(1);
    @(negedge Hclk);
    chk("resetup_cnt", 32'(cnt[2]), 32'h1);
    xfer_model(2, 1'b0, 32'h8000_000C, 32'h0, "resetup_old");
    xfer_model(2, 1'b0, 32'h8000_0014, 32'h0, "resetup_new");
    idle(1);

    // 300 more violations: counter sticks at 8'hFF.
    @(negedge Hclk);
    Pselx   = 3'b010;
    Penable = 1'b1;
    repeat (252) @(posedge Hclk);
    @(negedge Hclk);
    chk("sat_cnt_fe", 32'(cnt[1]), 32'hFE);
    @(posedge Hclk);
    @(negedge Hclk);
    chk("sat_cnt_ff", 32'(cnt[1]), 32'hFF);
    repeat (47) @(posedge Hclk);
    @(negedge Hclk);
    chk("sat_cnt_hold", 32'(cnt[1]), 32'hFF);
    for (int k = 0; k < 300; k++) bump(1);
    idle(1);

    // Back-to-back fills and readback of every register.
    for (int s = 0; s < 2; s++) begin
      for (int r = 0; r < 16; r++)
        xfer_model(s, 1'b1, BASE + 32'(4 * r), $urandom, "b2b_wr");
      for (int r = 0; r < 16; r++)
        xfer_model(s, 1'b0, BASE + 32'(4 * r), 32'h0, "b2b_rd");
      idle(1);
    end

    // Randomized transfers against the model.
    for (int n = 0; n < 200; n++) begin
      int          s;
      bit          w;
      int          pick;
      logic [31:0] a;
      s    = int'($urandom_range(0, 2));
      w    = 1'($urandom_range(0, 1));
      pick = int'($urandom_range(0, 15));
      a    = BASE + 32'(4 * $urandom_range(0, 17));
      if (pick == 0) a = a | 32'($urandom_range(1, 3));
      if (pick == 1) a = BASE - 32'(4 * $urandom_range(1, 4));
      xfer_model(s, w, a, $urandom, "rand");
      if ($urandom_range(0, 2) == 0) idle(int'($urandom_range(1, 2)));
    end
    idle(2);

    @(negedge Hclk);
    for (int s = 0; s < 3; s++)
      chk($sformatf("final_cnt%0d", s), 32'(cnt[s]), 32'(m_cnt[s]));

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
